regfile_wb_scoreboard: RTL

//  Register file and pending-write scoreboard at the receiving end of the MEM/WB writeback interface.
//  - Accepts the write-back triple (data, write-enable, address) from the MEM/WB pipeline register.
//  - Provides two combinational read ports with write-through bypass.
//  - Counts in-flight writes per register, issued from decode and retired by writeback.
//  - Raises a stall to decode on RAW hazards or when a pending-write counter is full.

---
 rtl/regfile_wb_scoreboard.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_scoreboard.sv
// Register file with write-through bypass and a pending-write scoreboard.
// Writebacks from MEM/WB update the array and retire in-flight writes.
// Decode issues bump per-register counters. Hazards and stall are
// combinational from the counters and the current inputs.
module regfile_wb_scoreboard #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PEND_WIDTH     = 2
) (
    input  logic                             i_Clk,
    input  logic                             i_Reset_n,
    input  logic                             i_Flush,
    input  logic [DATA_WIDTH-1:0]            i_WriteBack_Data,
    input  logic                             i_Writes_Back,
    input  logic [REG_ADDR_WIDTH-1:0]        i_Write_Addr,
    input  logic [REG_ADDR_WIDTH-1:0]        i_Read_Addr1,
    input  logic [REG_ADDR_WIDTH-1:0]        i_Read_Addr2,
    input  logic                             i_Read1_Used,
    input  logic                             i_Read2_Used,
    input  logic                             i_Issue_Valid,
    input  logic                             i_Issue_Writes,
    input  logic [REG_ADDR_WIDTH-1:0]        i_Issue_Dest,
    output logic [DATA_WIDTH-1:0]            o_Read_Data1,
    output logic [DATA_WIDTH-1:0]            o_Read_Data2,
    output logic                             o_Hazard1,
    output logic                             o_Hazard2,
    output logic                             o_Stall,
    output logic [(2**REG_ADDR_WIDTH)-1:0]   o_Pending
);

    localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

    logic [DATA_WIDTH-1:0] regs_q  [NUM_REGS];
    logic [PEND_WIDTH-1:0] count_q [NUM_REGS];
    logic [PEND_WIDTH-1:0] count_d [NUM_REGS];

    logic wb_valid;
    logic wb_hits_rd1;
    logic wb_hits_rd2;
    logic wb_hits_dest;
    logic dest_full;
    logic issue_inc;
    logic wb_dec;

    // Writeback qualification; register 0 is never a real target.
    always_comb begin
        wb_valid     = i_Writes_Back && (i_Write_Addr != '0);
        wb_hits_rd1  = wb_valid && (i_Write_Addr == i_Read_Addr1);
        wb_hits_rd2  = wb_valid && (i_Write_Addr == i_Read_Addr2);
        wb_hits_dest = wb_valid && (i_Write_Addr == i_Issue_Dest);
    end

    // Register array: async clear, writeback write; flush does not gate it.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wb_valid) begin
            regs_q[i_Write_Addr] <= i_WriteBack_Data;
        end
    end

    // Read ports with write-through bypass; r0 always reads zero.
    always_comb begin
        o_Read_Data1 = '0;
        o_Read_Data2 = '0;
        if (i_Read_Addr1 != '0) begin
            o_Read_Data1 = wb_hits_rd1 ? i_WriteBack_Data : regs_q[i_Read_Addr1];
        end
        if (i_Read_Addr2 != '0) begin
            o_Read_Data2 = wb_hits_rd2 ? i_WriteBack_Data : regs_q[i_Read_Addr2];
        end
    end

    // Source hazards: a lone pending write being written back now is
    // resolved by the bypass, so it does not count as a hazard.
    always_comb begin
        o_Hazard1 = (i_Read_Addr1 != '0) && (count_q[i_Read_Addr1] != '0) &&
                    !((count_q[i_Read_Addr1] == PEND_ONE) && wb_hits_rd1);
        o_Hazard2 = (i_Read_Addr2 != '0) && (count_q[i_Read_Addr2] != '0) &&
                    !((count_q[i_Read_Addr2] == PEND_ONE) && wb_hits_rd2);
    end

    // Issue stall: used-source hazard or saturated destination counter
    // (a same-cycle retire on the destination frees one slot).
    always_comb begin
        dest_full = i_Issue_Writes && (i_Issue_Dest != '0) &&
                    (count_q[i_Issue_Dest] == PEND_MAX) && !wb_hits_dest;
        o_Stall   = i_Issue_Valid &&
                    ((o_Hazard1 && i_Read1_Used) ||
                     (o_Hazard2 && i_Read2_Used) ||
                     dest_full);
        issue_inc = i_Issue_Valid && !o_Stall && i_Issue_Writes && (i_Issue_Dest != '0);
        wb_dec    = wb_valid && (count_q[i_Write_Addr] != '0);
    end

    // Counter next state: flush wins, then inc/dec cancel, else step.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            count_d[r] = count_q[r];
            if (i_Flush) begin
                count_d[r] = '0;
            end else if (issue_inc && (i_Issue_Dest == REG_ADDR_WIDTH'(r)) &&
                         !(wb_dec && (i_Write_Addr == REG_ADDR_WIDTH'(r)))) begin
                count_d[r] = count_q[r] + PEND_ONE;
            end else if (wb_dec && (i_Write_Addr == REG_ADDR_WIDTH'(r)) &&
                         !(issue_inc && (i_Issue_Dest == REG_ADDR_WIDTH'(r)))) begin
                count_d[r] = count_q[r] - PEND_ONE;
            end
        end
    end

    // Pending-write counters with async clear.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                count_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                count_q[r] <= count_d[r];
            end
        end
    end

    // Pending flags straight from the registered counters.
    always_comb begin
        o_Pending = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            o_Pending[r] = (count_q[r] != '0);
        end
    end

endmodule
